// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for the seven-segment scanner: load/value
// request from the datapath and the multiplexed pin outputs.
interface seven_seg_scanner_if #(
    parameter int DIGITS = 4
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  Load;
    logic [4*DIGITS-1:0]   Value;
    logic [DIGITS-1:0]     DpIn;
    logic [6:0]            Segments;
    logic                  Dp;
    logic [DIGITS-1:0]     Anode;
    logic [IDX_W-1:0]      DigitIdx;

    modport master (
        output Load, Value, DpIn,
        input  Segments, Dp, Anode, DigitIdx
    );

    modport slave (
        input  Load, Value, DpIn,
        output Segments, Dp, Anode, DigitIdx
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit hex seven-segment driver with shadow register.
// SEVENSEG_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module seven_seg_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                Clock,
    input  logic                Reset,
    seven_seg_scanner_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] val_q, val_d;
    logic [DIGITS-1:0]   dpr_q, dpr_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [IDX_W-1:0]    didx_q, didx_d;

    logic [3:0]          nib;
    logic                dp_sel;
    logic                blank;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0]    msd;
`endif

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        val_d = bus.Load ? bus.Value : val_q;
        dpr_d = bus.Load ? bus.DpIn  : dpr_q;
    end

    // Outputs are built from the pre-edge index, giving one cycle latency
    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib    = val_q[4*i +: 4];
                dp_sel = dpr_q[i];
            end
        end
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        msd = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (val_q[4*i +: 4] != 4'h0) msd = IDX_W'(i);
        end
        blank = (idx_q > msd) && !dp_sel;
`else
        blank = 1'b0;
`endif
        seg_d  = blank ? 7'h7F : hex_decode(nib);
        dp_d   = blank ? 1'b1  : ~dp_sel;
        an_d   = blank ? '1    : ~(DIGITS'(1) << idx_q);
        didx_d = idx_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            val_q  <= '0;
            dpr_q  <= '0;
            seg_q  <= 7'h7F;
            dp_q   <= 1'b1;
            an_q   <= '1;
            didx_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            val_q  <= val_d;
            dpr_q  <= dpr_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
            didx_q <= didx_d;
        end
    end

    assign bus.Segments = seg_q;
    assign bus.Dp       = dp_q;
    assign bus.Anode    = an_q;
    assign bus.DigitIdx = didx_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a cycle-count
// reference model of the scan, shadow and decode rules.
module tb_seven_seg_scanner;
    localparam int D  = 4;
    localparam int RD = 4;
    localparam int IW = 2;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic rst;

    seven_seg_scanner_if #(.DIGITS(D)) bus ();

    seven_seg_scanner #(.DIGITS(D), .REFRESH_DIV(RD)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [4*D-1:0] m_val;
    logic [D-1:0]   m_dp;
    int             m_t;
    logic [6:0]     e_seg;
    logic           e_dp;
    logic [D-1:0]   e_an;
    logic [IW-1:0]  e_idx;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected display for the digit selected by the scan position
    function automatic void model_out(input int idx);
        logic [3:0] n;
        bit         blank;
        int         top;
        n     = m_val[4*idx +: 4];
        blank = 1'b0;
        top   = 0;
        for (int i = 0; i < D; i++)
            if (m_val[4*i +: 4] != 4'h0) top = i;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
        blank = (idx > top) && !m_dp[idx];
`endif
        e_idx = IW'(idx);
        if (blank) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_an  = '1;
        end else begin
            e_seg     = SEG_TBL[n];
            e_dp      = ~m_dp[idx];
            e_an      = '1;
            e_an[idx] = 1'b0;
        end
    endfunction

    task automatic step();
        int idx;
        @(posedge clk);
        if (rst) begin
            e_an  = '1;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            e_idx = '0;
            m_t   = 0;
            m_val = '0;
            m_dp  = '0;
        end else begin
            idx = (m_t / RD) % D;
            model_out(idx);
            if (bus.Load) begin
                m_val = bus.Value;
                m_dp  = bus.DpIn;
            end
            m_t++;
        end
        @(negedge clk);
        chk("anode", 32'(bus.Anode), 32'(e_an));
        chk("segments", 32'(bus.Segments), 32'(e_seg));
        chk("dp", 32'(bus.Dp), 32'(e_dp));
        chk("digit_idx", 32'(bus.DigitIdx), 32'(e_idx));
    endtask

    task automatic load_once(input logic [4*D-1:0] v, input logic [D-1:0] dp);
        bus.Load  = 1'b1;
        bus.Value = v;
        bus.DpIn  = dp;
        step();
        bus.Load  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.Load  = 1'b0;
        bus.Value = '0;
        bus.DpIn  = '0;
        m_val     = '0;
        m_dp      = '0;
        m_t       = 0;

        // Reset held three cycles, then first digit after release
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        step();
        chk("first_anode", 32'(bus.Anode), 32'h0000_000E);
        chk("first_seg", 32'(bus.Segments), 32'h0000_0040);

        // Scan of 12AF over two frames
        load_once(16'h12AF, 4'b0000);
        for (int i = 0; i < 2 * D * RD; i++) step();

        // Every nibble value through the decoder
        for (int v = 0; v < 16; v++) begin
            load_once({D{4'(v)}}, 4'(v));
            for (int i = 0; i < RD; i++) step();
        end

        // Load on the terminal-count edge
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < RD && (m_t % RD) != RD - 1; i++) step();
            chk("tc_align", 32'(m_t % RD), 32'(RD - 1));
            load_once(16'($urandom), 4'($urandom));
            for (int i = 0; i < RD + 1; i++) step();
        end

        // Reset while digit 2 is on the pins
        load_once(16'h5678, 4'b1010);
        for (int i = 0; i < 2 * D * RD && e_idx != 2; i++) step();
        chk("mid_idx", 32'(e_idx), 32'd2);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < D * RD + 2; i++) step();

        // Leading-zero case with a decimal point on digit 2
        load_once(16'h003A, 4'b0100);
        for (int i = 0; i < D * RD + 1; i++) step();
        load_once(16'h0000, 4'b0000);
        for (int i = 0; i < D * RD; i++) step();

        // Random loads with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            bus.Load  = ($urandom_range(0, 3) == 0);
            bus.Value = 16'($urandom);
            bus.DpIn  = 4'($urandom);
            if ($urandom_range(0, 2) == 0) bus.Value[15:8] = '0;
            step();
        end
        rst      = 1'b0;
        bus.Load = 1'b0;

        // Load held high tracks Value
        bus.Load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.Value = 16'($urandom);
            bus.DpIn  = 4'($urandom);
            step();
        end
        bus.Load = 1'b0;
        for (int i = 0; i < D * RD; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
